// File: rtl/display_cmd_scheduler_if.sv
// Avalon-MM slave command/status port of the display command scheduler.
interface display_cmd_scheduler_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic        address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output chipselect, write, read, address, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, write, read, address, writedata,
    output readdata
  );
endinterface

// File: rtl/display_cmd_scheduler.sv
// Buffers CPU display commands and replays them onto the broadcast bus; frame commits are held
// until vblank start. Optional macro DISPLAY_SCHED_OVF_COUNT_EN adds a dropped-write counter.
module display_cmd_scheduler #(
  parameter int FIFO_DEPTH = 16,
  parameter int V_ACTIVE   = 480
) (
  input  logic                      clk,
  input  logic                      reset,
  display_cmd_scheduler_if.slave    avalon,
  input  logic [9:0]                hcount,
  input  logic [9:0]                vcount,
  output logic [31:0]               cmd_out,
  output logic                      back_buf,
  output logic                      front_buf,
  output logic                      frame_sync
);
  localparam int         AW          = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_LEVEL  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);
  localparam logic [9:0] VB_LINE     = 10'(V_ACTIVE);
  localparam logic [3:0] INFO_COMMIT = 4'b1111;

  typedef enum logic [1:0] {IDLE, WAIT_VB, SWAP} state_t;

  state_t         state, state_next;
  logic [32:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic [32:0]    head;
  logic           full, empty, push_req, push, drop, pop, ctrl_clear;
  logic           in_vb, in_vb_d, vb_event;
  logic [31:0]    cmd_next;
  logic           swap_done;
  logic [15:0]    frame_count;
  logic           ovf_sticky;
  logic [4:0]     ovf_field;
  logic [31:0]    status;
  logic           unused_bits;

  assign full       = (count == FULL_LEVEL);
  assign empty      = (count == '0);
  assign push_req   = avalon.chipselect & avalon.write & ~avalon.address;
  assign push       = push_req & ~full;
  assign drop       = push_req & full;
  assign ctrl_clear = avalon.chipselect & avalon.write & avalon.address & avalon.writedata[0];
  assign head       = mem[rd_ptr];

  // NOTE: the storage array has no reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {(avalon.writedata[20:17] == INFO_COMMIT), avalon.writedata};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE_PTR;
      if (pop)  rd_ptr <= rd_ptr + ONE_PTR;
      case ({push, pop})
        2'b10:   count <= count + ONE_LEVEL;
        2'b01:   count <= count - ONE_LEVEL;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_vb   <= 1'b0;
      in_vb_d <= 1'b0;
    end else begin
      in_vb   <= (vcount >= VB_LINE);
      in_vb_d <= in_vb;
    end
  end
  assign vb_event = in_vb & ~in_vb_d;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!empty && head[32]) state_next = WAIT_VB;
      WAIT_VB: if (vb_event)           state_next = SWAP;
      SWAP:                            state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    cmd_next  = '0;
    pop       = 1'b0;
    swap_done = 1'b0;
    unique case (state)
      IDLE: if (!empty && !head[32]) begin
        pop      = 1'b1;
        cmd_next = {head[31:14], back_buf, head[12:0]};
      end
      WAIT_VB: if (vb_event) begin
        pop      = 1'b1;
        cmd_next = {11'b0, INFO_COMMIT, 3'b0, back_buf, 13'b0};
      end
      SWAP:    swap_done = 1'b1;
      default: ;
    endcase
  end

  // The swap command goes out stamped with the old buffer; the toggle lands one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_out     <= '0;
      back_buf    <= 1'b1;
      frame_sync  <= 1'b0;
      frame_count <= '0;
    end else begin
      cmd_out    <= cmd_next;
      frame_sync <= swap_done;
      if (swap_done) begin
        back_buf    <= ~back_buf;
        frame_count <= frame_count + 16'd1;
      end
    end
  end
  assign front_buf = ~back_buf;

  always_ff @(posedge clk) begin
    if (reset)           ovf_sticky <= 1'b0;
    else if (ctrl_clear) ovf_sticky <= 1'b0;
    else if (drop)       ovf_sticky <= 1'b1;
  end

`ifdef DISPLAY_SCHED_OVF_COUNT_EN
  logic [4:0] ovf_count;
  always_ff @(posedge clk) begin
    if (reset)                              ovf_count <= '0;
    else if (ctrl_clear)                    ovf_count <= '0;
    else if (drop && ovf_count != 5'd31)    ovf_count <= ovf_count + 5'd1;
  end
  assign ovf_field = ovf_count;
`else
  assign ovf_field = 5'd0;
`endif

  assign status = {frame_count, ovf_field, ovf_sticky, (state == WAIT_VB), back_buf, 8'(count)};

  always_ff @(posedge clk) begin
    if (reset)                                avalon.readdata <= '0;
    else if (avalon.chipselect && avalon.read) avalon.readdata <= status;
  end

  // Raster column and the CPU's own pp_selc bit play no part in scheduling.
  assign unused_bits = ^{hcount, head[13]};
endmodule

// File: doc/display_cmd_scheduler.md
# display_cmd_scheduler

Sits between the Avalon command port and the broadcast 32-bit command bus that feeds every display component (ground, sprites, background), which decode `sub_comp`/`info`/`input_type`/`pp_selc`. It buffers CPU command writes in a FIFO and replays them one per clock onto the bus, stamping the current back-buffer index into `pp_selc`. It defers each frame-commit token to the next vertical-blank start, then emits the flush/swap command, so buffer swaps never tear mid-frame.

## Interface
- `FIFO_DEPTH`, 16: command FIFO entries; power of two, 4..128.
- `V_ACTIVE`, 480: first non-visible `vcount` line; vblank region is `vcount >= V_ACTIVE`.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `chipselect` in 1: Avalon slave select.
- `write` in 1: Avalon write strobe.
- `read` in 1: Avalon read strobe.
- `address` in 1: 0 = command/status, 1 = control.
- `writedata` in 32: command word (`[31:26]` sub_comp, `[25:21]` child, `[20:17]` info, `[16:14]` type, `[13]` pp_selc, `[12:0]` msg).
- `readdata` out 32: status word.
- `hcount` in 10, `vcount` in 10: raster position from the VGA timing block.
- `cmd_out` out 32: broadcast command bus; 0 = no-op (info 0000).
- `back_buf` out 1: buffer currently being written.
- `front_buf` out 1: buffer currently displayed; always `~back_buf`.
- `frame_sync` out 1: one-cycle pulse on the cycle after a swap command is issued.

## Operation
- **Push:**
  - `chipselect & write & address==0` pushes `{commit, writedata}`, with `commit = (writedata[20:17]==4'b1111)`.
  - If FIFO full: word dropped, overflow flag set.
  - Full/empty come from the registered count only; a same-cycle pop does not free a slot for a push.
- **Control:** `chipselect & write & address==1` with `writedata[0]=1` clears overflow state. Other bits are ignored.
- **Status read:**
  - `chipselect & read` (either address) registers `readdata`, one-cycle latency.
  - Fields: `[7:0]` FIFO level, `[8]` back_buf, `[9]` waiting-for-vblank, `[10]` overflow sticky, `[15:11]` 0, `[31:16]` frame_count.
- **Vblank-start event:** registered `in_vb = (vcount >= V_ACTIVE)`. The event is `in_vb` rising. At most one event per frame.
- **FSM:**
  - IDLE
    - FIFO empty: `cmd_out` = 0.
    - Head is normal: pop; `cmd_out <= {w[31:14], back_buf, w[12:0]}`; stay IDLE. This allows back-to-back issue, one command per clock.
    - Head is commit: do not pop; go to WAIT_VB; `cmd_out` = 0.
  - WAIT_VB: `cmd_out` = 0. Commands behind the commit stay queued because they belong to the next frame. On the vblank-start event, go to SWAP.
  - SWAP (one cycle):
    - `cmd_out <= {11'b0, 4'b1111, 3'b0, back_buf, 13'b0}`; pop the commit.
    - Next cycle: `back_buf` toggles, `frame_sync`=1, `frame_count` increments (16-bit, wraps).
    - Return to IDLE.
  - A commit arriving while already inside vblank waits for the next frame's event. Consecutive commits each consume one frame.
- CPU-supplied `pp_selc` is always overwritten.

## Timing
- **Reset values:**
  - `cmd_out`=0, `back_buf`=1, `front_buf`=0, `frame_sync`=0, `readdata`=0.
  - FIFO empty, overflow cleared, frame_count=0, FSM=IDLE.
- **Reset mid-operation:** queued commands and any pending commit are discarded, and no flush is emitted. Outputs hold reset values on the cycle after reset is sampled.
- **Latency:** a write sampled at edge E into an empty FIFO drives `cmd_out` from edge E+2. The bus returns to 0 at E+3 unless another command follows.
- **Swap latency:** vblank rising at `vcount` sampled at edge V gives `in_vb` at V+1 and the SWAP command at edge V+2. `back_buf` toggles and `frame_sync` pulses at V+3.
- **`cmd_out` lifetime:** every nonzero `cmd_out` lasts exactly one cycle.

## Configuration
- **Macro:** `DISPLAY_SCHED_OVF_COUNT_EN`.
- **Defined:** status `[15:11]` is a saturating count of dropped writes (holds at 31). It is cleared together with the sticky flag by the control write.
- **Undefined:** `[15:11]` reads 0; only the sticky bit `[10]` reports overflow.

## Test plan
- **Basic issue:** after reset, write 0x3C020001 then 0x3C038005 on consecutive cycles. Expect `cmd_out`=0x3C022001 then 0x3C03A005 on consecutive cycles (bit 13 forced to 1), then 0.
- **Deferred swap:** with `vcount`=100, write commit 0x001E0000 followed by a normal command.
  - `cmd_out` stays 0 and status[9]=1 until `vcount` reaches 480.
  - Then `cmd_out`=0x001E2000 for one cycle; next cycle `back_buf`=0, `frame_sync`=1, frame_count=1.
  - The queued normal command issues afterwards with bit 13=0.
- **Overflow:** hold FSM in WAIT_VB and write FIFO_DEPTH+3 words.
  - Status level = 16, [10]=1, and [15:11]=3 with the macro (0 without).
  - Control write 0x1 clears both.
- **Commit in vblank:** issue a commit while `vcount`=500. No swap occurs until the next 479→480 transition. Two queued commits produce swaps on two successive frames.
- **Reset mid-operation:** assert `reset` during WAIT_VB with 5 queued entries. Expect status level=0, `back_buf`=1, and `cmd_out`=0 through the following vblank.
